// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: key, tick and miss inputs plus ball/score/status outputs of the pong game sequencer
interface pong_game_ctrl_if #(
    parameter int SCORE_W = 3
);
    logic               frame_tick_i;
    logic               start_key_i;
    logic               miss_left_i;
    logic               miss_right_i;
    logic               ball_move_en_o;
    logic               ball_reset_o;
    logic               serve_dir_o;
    logic [SCORE_W-1:0] score_left_o;
    logic [SCORE_W-1:0] score_right_o;
    logic               game_over_o;
    logic               winner_o;
    logic [2:0]         state_o;

    modport master (
        output frame_tick_i, start_key_i, miss_left_i, miss_right_i,
        input  ball_move_en_o, ball_reset_o, serve_dir_o, score_left_o, score_right_o,
        input  game_over_o, winner_o, state_o
    );

    modport slave (
        input  frame_tick_i, start_key_i, miss_left_i, miss_right_i,
        output ball_move_en_o, ball_reset_o, serve_dir_o, score_left_o, score_right_o,
        output game_over_o, winner_o, state_o
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong match sequencer (serve delay, per-frame ball motion, scoring, match end); PONG_PAUSE_EN adds a start-key pause in play
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    localparam int SCORE_W     = $clog2(WIN_SCORE + 1)
) (
    input logic             clk_i,
    input logic             rst_n_i,
    pong_game_ctrl_if.slave bus
);
    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               move_q, move_d;
    logic               ball_reset_q, game_over_q;
    logic               start_prev_q, armed_q;
    logic               start_edge, miss_any, serve_done;

    // the armed flag masks the first sample after reset so a key held through reset is not an edge
    assign start_edge = armed_q & bus.start_key_i & ~start_prev_q;
    assign miss_any   = bus.miss_left_i | bus.miss_right_i;
    assign serve_done = cnt_q == CNT_W'(SERVE_FRAMES - 1);

    // start-key edge detector
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            start_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            start_prev_q <= bus.start_key_i;
            armed_q      <= 1'b1;
        end
    end

    // state, scores and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            score_l_q    <= '0;
            score_r_q    <= '0;
            cnt_q        <= '0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 1'b0;
            move_q       <= 1'b0;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            cnt_q        <= cnt_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            move_q       <= move_d;
            ball_reset_q <= state_d != PLAY && state_d != PAUSE;
            game_over_q  <= state_d == OVER;
        end
    end

    // next-state, scoring and move-pulse decisions
    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        cnt_d       = cnt_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        move_d      = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_d   = SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    cnt_d     = '0;
                end
            end
            SERVE: begin
                if (bus.frame_tick_i) begin
                    state_d = serve_done ? PLAY : SERVE;
                    cnt_d   = serve_done ? '0 : cnt_q + 1'b1;
                end
            end
            PLAY: begin
                if (miss_any) begin
                    state_d = POINT;
                    if (bus.miss_left_i && !bus.miss_right_i) begin
                        score_r_d   = score_r_q == SCORE_W'(WIN_SCORE) ? score_r_q : score_r_q + 1'b1;
                        serve_dir_d = 1'b0;
                    end else if (bus.miss_right_i && !bus.miss_left_i) begin
                        score_l_d   = score_l_q == SCORE_W'(WIN_SCORE) ? score_l_q : score_l_q + 1'b1;
                        serve_dir_d = 1'b1;
                    end
                end
`ifdef PONG_PAUSE_EN
                else if (start_edge) state_d = PAUSE;
`endif
                else move_d = bus.frame_tick_i;
            end
            POINT: begin
                if (score_l_q == SCORE_W'(WIN_SCORE)) begin
                    state_d  = OVER;
                    winner_d = 1'b0;
                end else if (score_r_q == SCORE_W'(WIN_SCORE)) begin
                    state_d  = OVER;
                    winner_d = 1'b1;
                end else begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            end
`ifdef PONG_PAUSE_EN
            PAUSE: begin
                if (start_edge) state_d = PLAY;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.ball_move_en_o = move_q;
    assign bus.ball_reset_o   = ball_reset_q;
    assign bus.serve_dir_o    = serve_dir_q;
    assign bus.score_left_o   = score_l_q;
    assign bus.score_right_o  = score_r_q;
    assign bus.game_over_o    = game_over_q;
    assign bus.winner_o       = winner_q;
    assign bus.state_o        = state_q;
endmodule
